// File: rtl/fc_feature_streamer.sv
// ---------------------------------------------------------------------------
// fc_feature_streamer
//
// Transmit-side front end for the FC/argmax classifier. Each 32-bit signed
// feature accumulation is requantized to an unsigned byte using ReLU, a right
// shift by SHIFT, and saturation at 255. A ping-pong pair of FEAT_DIM-byte
// banks holds the frames. Each full frame is then streamed as one contiguous
// out_valid burst. After every burst the output is held idle for GAP_CYCLES
// cycles, which gives the classifier time to finish its argmax pass.
//
// Parameters
//   FEAT_DIM   : bytes per frame (must equal classifier IN_DIM)
//   SHIFT      : requantization right shift (0..31)
//   GAP_CYCLES : idle cycles enforced after each burst (>= classifier OUT_DIM)
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_data    : signed feature value from the pooling stage
//   in_valid   : in_data valid; a sample is taken when in_valid && in_ready
//   in_ready   : the current write bank is free
//   out_data   : requantized byte to the classifier (registered)
//   out_valid  : out_data valid (registered)
//   frame_done : one-cycle pulse in the cycle after a burst's last byte
//   busy       : a bank holds data, or the send FSM is not idle
//   sat_count  : saturated-sample count of the last completed frame
//                (present only when FC_STREAM_SATCNT_EN is defined)
//
// Optional feature macro: FC_STREAM_SATCNT_EN
// ---------------------------------------------------------------------------
module fc_feature_streamer #(
  parameter int FEAT_DIM   = 32,
  parameter int SHIFT      = 8,
  parameter int GAP_CYCLES = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        frame_done,
`ifdef FC_STREAM_SATCNT_EN
  output logic [15:0] sat_count,
`endif
  output logic        busy
);

  localparam int IDX_W = (FEAT_DIM > 1) ? $clog2(FEAT_DIM) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FEAT_DIM - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  // -------------------------------------------------------------------------
  // Requantization: ReLU, shift, saturate.
  // -------------------------------------------------------------------------
  logic [31:0] shifted;
  logic        clamp;
  logic [7:0]  q_byte;

  always_comb begin
    // The shift is logical, not arithmetic. Negative inputs are forced to 0
    // before the shift result is used, so the two give the same byte.
    shifted = in_data >> SHIFT;
    clamp   = !in_data[31] && (shifted[31:8] != '0);
    if (in_data[31])  q_byte = 8'h00;
    else if (clamp)   q_byte = 8'hFF;
    else              q_byte = shifted[7:0];
  end

  // -------------------------------------------------------------------------
  // Ping-pong storage and fill side
  // -------------------------------------------------------------------------
  logic [7:0]       mem [2][FEAT_DIM];
  logic [1:0]       full;
  logic             wr_bank;
  logic [IDX_W-1:0] wr_idx;
  logic             accept;
  logic             wr_last;
  logic             release_bank;

  logic             rd_bank;
  logic [IDX_W-1:0] rd_idx,  rd_idx_d;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_d;
  state_t           state,   state_d;
  logic [7:0]       out_data_d;
  logic             out_valid_d;
  logic             frame_done_d;

  assign in_ready = !full[wr_bank];
  assign accept   = in_valid && in_ready;
  assign wr_last  = accept && (wr_idx == LAST_IDX);
  assign busy     = (|full) || (state != S_IDLE);

  // NOTE: the frame storage has no reset. The full flags decide which bytes
  // are valid, so resetting the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_bank][wr_idx] <= q_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
      wr_idx  <= '0;
    end else if (accept) begin
      if (wr_idx == LAST_IDX) begin
        wr_bank <= ~wr_bank;
        wr_idx  <= '0;
      end else begin
        wr_idx  <= wr_idx + 1'b1;
      end
    end
  end

  // A bank is only set while it is empty and only cleared while it is full.
  // The set and the clear in one cycle therefore never target the same bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= '0;
    end else begin
      if (wr_last)      full[wr_bank] <= 1'b1;
      if (release_bank) full[rd_bank] <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Send FSM: next-state and next-output logic
  // -------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first. This prevents
  // latch inference on paths that do not assign it.
  always_comb begin
    state_d      = state;
    rd_idx_d     = rd_idx;
    gap_cnt_d    = gap_cnt;
    release_bank = 1'b0;
    out_valid_d  = 1'b0;
    out_data_d   = out_data;   // hold last byte while idle
    frame_done_d = 1'b0;
    case (state)
      S_IDLE: begin
        if (full[rd_bank]) begin
          state_d  = S_SEND;
          rd_idx_d = '0;
        end
      end
      S_SEND: begin
        out_valid_d = 1'b1;
        out_data_d  = mem[rd_bank][rd_idx];
        if (rd_idx == LAST_IDX) begin
          state_d   = S_GAP;
          gap_cnt_d = '0;
        end else begin
          rd_idx_d  = rd_idx + 1'b1;
        end
      end
      S_GAP: begin
        // The first gap cycle is the one where out_valid first goes low,
        // which is the cycle right after the last byte.
        frame_done_d = (gap_cnt == '0);
        if (gap_cnt == LAST_GAP) begin
          release_bank = 1'b1;
          state_d      = S_IDLE;
        end else begin
          gap_cnt_d    = gap_cnt + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples its pre-edge inputs, whatever order the blocks run in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      rd_bank    <= 1'b0;
      rd_idx     <= '0;
      gap_cnt    <= '0;
      out_data   <= 8'h00;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      rd_idx     <= rd_idx_d;
      gap_cnt    <= gap_cnt_d;
      out_data   <= out_data_d;
      out_valid  <= out_valid_d;
      frame_done <= frame_done_d;
      if (release_bank) rd_bank <= ~rd_bank;
    end
  end

`ifdef FC_STREAM_SATCNT_EN
  // -------------------------------------------------------------------------
  // Per-frame saturation counter. The count is held once the frame completes.
  // -------------------------------------------------------------------------
  logic [15:0] sat_run;
  logic [15:0] sat_hold;
  logic [15:0] sat_next;

  assign sat_next  = (clamp && (sat_run != 16'hFFFF)) ? sat_run + 16'd1 : sat_run;
  assign sat_count = sat_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_run  <= '0;
      sat_hold <= '0;
    end else if (accept) begin
      if (wr_idx == LAST_IDX) begin
        sat_hold <= sat_next;
        sat_run  <= '0;
      end else begin
        sat_run  <= sat_next;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fc_feature_streamer.sv
// ---------------------------------------------------------------------------
// tb_fc_feature_streamer
//
// Scoreboard bench for fc_feature_streamer. The driver pushes the expected
// byte for each sample as the sample is accepted. A monitor running on the
// falling edge pops and compares every out_valid byte. The monitor also
// checks burst length, frame_done placement and the gap between bursts.
// Define FC_STREAM_SATCNT_EN to include the sat_count checks.
// ---------------------------------------------------------------------------
module tb_fc_feature_streamer;

  localparam int FEAT = 32;
  localparam int GAP  = 12;
  localparam int TMO  = 2000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        frame_done;
  logic        busy;
`ifdef FC_STREAM_SATCNT_EN
  logic [15:0] sat_count;
`endif

  fc_feature_streamer #(.FEAT_DIM(FEAT), .SHIFT(8), .GAP_CYCLES(GAP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .frame_done (frame_done),
`ifdef FC_STREAM_SATCNT_EN
    .sat_count  (sat_count),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q [$];
  logic [31:0] vec_data [FEAT];
  logic [7:0]  vec_exp  [FEAT];
  int         bytes_seen = 0;
  bit         saw_stall = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s @%0t", name, $time);
  endtask

  // Called and returns on a falling edge. Holds the sample until it is
  // accepted, then records the expected byte.
  task automatic put(input logic [31:0] d, input logic [7:0] e);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && t < TMO) begin
      saw_stall = 1'b1;
      @(negedge clk);
      t++;
    end
    if (t >= TMO) fail("in_ready_timeout");
    @(posedge clk);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input bit toggle);
    for (int i = 0; i < FEAT; i++) begin
      put(vec_data[i], vec_exp[i]);
      if (toggle) idle(1);
    end
  endtask

  task automatic load_ramp(input int base);
    for (int i = 0; i < FEAT; i++) begin
      vec_data[i] = 32'(base + i) << 8;
      vec_exp[i]  = 8'(base + i);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    in_valid = 1'b0;
    @(negedge clk);
    while (busy && t < TMO) begin
      @(negedge clk);
      t++;
    end
    if (t >= TMO) fail("busy_timeout");
    repeat (2) @(negedge clk);
  endtask

  // ------------------------------------------------------------------ monitor
  initial begin
    bit prev_valid = 0;
    bit seen_burst = 0;
    int run_len = 0;
    int gap_len = 0;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 0;
        seen_burst = 0;
        run_len    = 0;
        gap_len    = 0;
      end else begin
        if (out_valid) begin
          if (!prev_valid) begin
            if (seen_burst && gap_len < GAP) begin
              checks++;
              errors++;
              $display("FAIL gap_len actual=%0d required>=%0d @%0t", gap_len, GAP, $time);
            end else if (seen_burst) begin
              checks++;
            end
            run_len = 0;
          end
          run_len++;
          bytes_seen++;
          if (exp_q.size() == 0) fail("unexpected_byte");
          else begin
            e = exp_q.pop_front();
            check("out_data", out_data, e);
          end
          check("frame_done_in_burst", frame_done, 0);
        end else if (prev_valid) begin
          check("burst_len", run_len, FEAT);
          check("frame_done_pulse", frame_done, 1);
          seen_burst = 1;
          gap_len    = 1;
        end else begin
          gap_len++;
          check("frame_done_idle", frame_done, 0);
        end
        prev_valid = out_valid;
      end
    end
  end

  // ----------------------------------------------------------------- stimulus
  initial begin
    int lat;
    int base;
    int t;

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready",   in_ready,   1);
    check("rst_out_data",   out_data,   0);
    check("rst_out_valid",  out_valid,  0);
    check("rst_frame_done", frame_done, 0);
    check("rst_busy",       busy,       0);
`ifdef FC_STREAM_SATCNT_EN
    check("rst_sat_count",  sat_count,  0);
`endif

    // Ramp frame: k<<8 gives byte k. Also checks the two-edge latency.
    load_ramp(0);
    send_frame(0);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 2);
    wait_idle();

    // Clamp frame
    load_ramp(0);
    for (int i = 3; i < FEAT; i++) vec_data[i] = (32'(i) << 8) | 32'h7F;
    vec_data[0] = 32'hFFFF_FFFB;  vec_exp[0] = 8'd0;
    vec_data[1] = 32'h0001_0000;  vec_exp[1] = 8'd255;
    vec_data[2] = 32'h0000_FF80;  vec_exp[2] = 8'd255;
    vec_data[3] = 32'h7FFF_FFFF;  vec_exp[3] = 8'd255;
    vec_data[4] = 32'h8000_0000;  vec_exp[4] = 8'd0;
    vec_data[5] = 32'h0000_00FF;  vec_exp[5] = 8'd0;
    send_frame(0);
    wait_idle();

    // Three frames back to back, in_valid held high.
    saw_stall = 0;
    for (int f = 0; f < 3; f++) begin
      load_ramp(40 * f);
      send_frame(0);
    end
    check("stall_seen", saw_stall, 1);
    wait_idle();

    // Toggling in_valid
    load_ramp(0);
    send_frame(1);
    wait_idle();

    // Reset at the 10th output byte
    load_ramp(100);
    send_frame(0);
    in_valid = 1'b0;
    base = bytes_seen;
    t = 0;
    while (bytes_seen != base + 10 && t < TMO) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t >= TMO) fail("reset_point_timeout");
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready",  in_ready,  1);
    check("post_rst_busy",      busy,      0);
    check("post_rst_out_valid", out_valid, 0);
    load_ramp(0);
    send_frame(0);
    wait_idle();

`ifdef FC_STREAM_SATCNT_EN
    load_ramp(0);
    for (int i = 0; i < 7; i++) begin
      vec_data[i] = 32'h0001_0000 * 32'(i + 1);
      vec_exp[i]  = 8'd255;
    end
    send_frame(0);
    check("sat_count_7", sat_count, 7);
    wait_idle();
    load_ramp(0);
    send_frame(0);
    check("sat_count_0", sat_count, 0);
    wait_idle();
`endif

    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog @%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
